sram_ctrl: RTL and testbench

Single-port SRAM controller sitting directly downstream of the codec's record/playback address and data outputs. It serves the codec's write channel (ADC samples during record) and read channel (samples for the DAC during playback) with a fixed, deterministic access sequence. It drives the external 256K×16 SRAM pins. It can also track the length of the current recording so playback past the end returns silence.

---
 rtl/sram_ctrl_if.sv | 38 +++
 rtl/sram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Request/acknowledge bundle between the codec record/playback channels and sram_ctrl.
// The record-length signals exist only when SRAM_CTRL_RECLEN_EN is defined.
interface sram_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ack;
    logic              busy;
`ifdef SRAM_CTRL_RECLEN_EN
    logic              rec_clear;
    logic [ADDR_W:0]   rec_len;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, rec_clear,
        input  wr_ack, rd_data, rd_ack, busy, rec_len
    );
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, rec_clear,
        output wr_ack, rd_data, rd_ack, busy, rec_len
    );
`else
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_data, rd_ack, busy
    );
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_data, rd_ack, busy
    );
`endif
endinterface

// File: rtl/sram_ctrl.sv
// Single-port async SRAM controller: read-priority arbitration, fixed access sequence, registered pins.
// Optional record-length tracking with silent reads past the end: define SRAM_CTRL_RECLEN_EN.
module sram_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1
) (
    input  logic              CLK50,
    input  logic              reset,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_WE,
    output logic              SRAM_UB,
    output logic              SRAM_LB
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_PULSE = 3'd2,
        WR_HOLD  = 3'd3,
        ACK      = 3'd4
    } state_t;

    localparam logic [1:0] RD_LAST = 2'(RD_WAIT);

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              is_rd_reg, is_rd_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic              ce_reg, ce_next;
    logic              oe_reg, oe_next;
    logic              we_reg, we_next;
    logic              dq_oe_reg, dq_oe_next;
    logic              rd_ack_reg, rd_ack_next;
    logic              wr_ack_reg, wr_ack_next;
`ifdef SRAM_CTRL_RECLEN_EN
    logic [ADDR_W:0]   rec_len_reg, rec_len_next;
    logic [ADDR_W:0]   wr_end;
`endif

    // Next-state and latched request fields
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        is_rd_next   = is_rd_reg;
        rd_data_next = rd_data_reg;
        case (state_reg)
            IDLE: begin
                if (bus.rd_req) begin
                    is_rd_next = 1'b1;
                    addr_next  = bus.rd_addr;
                    cnt_next   = 2'd0;
`ifdef SRAM_CTRL_RECLEN_EN
                    // Beyond the recording: answer with silence, no SRAM cycle
                    if ({1'b0, bus.rd_addr} >= rec_len_reg) begin
                        state_next   = ACK;
                        rd_data_next = '0;
                    end else begin
                        state_next = RD;
                    end
`else
                    state_next = RD;
`endif
                end else if (bus.wr_req) begin
                    is_rd_next = 1'b0;
                    addr_next  = bus.wr_addr;
                    wdata_next = bus.wr_data;
                    state_next = WR_PULSE;
                end
            end
            RD: begin
                if (cnt_reg == RD_LAST) begin
                    rd_data_next = SRAM_DQ;
                    state_next   = ACK;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            WR_PULSE: state_next = WR_HOLD;
            WR_HOLD:  state_next = ACK;
            ACK:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Pin values are decoded from the next state so the flops line up with the state register
    always_comb begin
        ce_next     = 1'b1;
        oe_next     = 1'b1;
        we_next     = 1'b1;
        dq_oe_next  = 1'b0;
        rd_ack_next = 1'b0;
        wr_ack_next = 1'b0;
        case (state_next)
            RD: begin
                ce_next = 1'b0;
                oe_next = 1'b0;
            end
            WR_PULSE: begin
                ce_next    = 1'b0;
                we_next    = 1'b0;
                dq_oe_next = 1'b1;
            end
            WR_HOLD: begin
                ce_next    = 1'b0;
                dq_oe_next = 1'b1;
            end
            ACK: begin
                rd_ack_next = is_rd_next;
                wr_ack_next = !is_rd_next;
            end
            default: begin
                ce_next = 1'b1;
            end
        endcase
    end

`ifdef SRAM_CTRL_RECLEN_EN
    assign wr_end = {1'b0, addr_reg} + (ADDR_W+1)'(1);

    always_comb begin
        rec_len_next = rec_len_reg;
        if (bus.rec_clear) begin
            rec_len_next = '0;
        end else if (state_reg == ACK && !is_rd_reg && wr_end > rec_len_reg) begin
            rec_len_next = wr_end;
        end
    end
`endif

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 2'd0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            is_rd_reg   <= 1'b0;
            rd_data_reg <= '0;
            ce_reg      <= 1'b1;
            oe_reg      <= 1'b1;
            we_reg      <= 1'b1;
            dq_oe_reg   <= 1'b0;
            rd_ack_reg  <= 1'b0;
            wr_ack_reg  <= 1'b0;
`ifdef SRAM_CTRL_RECLEN_EN
            rec_len_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            is_rd_reg   <= is_rd_next;
            rd_data_reg <= rd_data_next;
            ce_reg      <= ce_next;
            oe_reg      <= oe_next;
            we_reg      <= we_next;
            dq_oe_reg   <= dq_oe_next;
            rd_ack_reg  <= rd_ack_next;
            wr_ack_reg  <= wr_ack_next;
`ifdef SRAM_CTRL_RECLEN_EN
            rec_len_reg <= rec_len_next;
`endif
        end
    end

    assign SRAM_ADDR = addr_reg;
    assign SRAM_CE   = ce_reg;
    assign SRAM_OE   = oe_reg;
    assign SRAM_WE   = we_reg;
    assign SRAM_UB   = 1'b0;
    assign SRAM_LB   = 1'b0;
    assign SRAM_DQ   = dq_oe_reg ? wdata_reg : {DATA_W{1'bz}};

    assign bus.rd_data = rd_data_reg;
    assign bus.rd_ack  = rd_ack_reg;
    assign bus.wr_ack  = wr_ack_reg;
    assign bus.busy    = (state_reg != IDLE);
`ifdef SRAM_CTRL_RECLEN_EN
    assign bus.rec_len = rec_len_reg;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: transaction-level memory/latency model plus directed corner cases.
// A second instance with RD_WAIT=3 covers the long read window.
`timescale 1ns/1ps
module tb_sram_ctrl;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Main instance and its SRAM model
    sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    wire  [DW-1:0] dq;
    logic [AW-1:0] sa;
    logic ce, oe, we, ub, lb;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RW)) u_dut (
        .CLK50(clk), .reset(rst), .bus(bus.slave),
        .SRAM_ADDR(sa), .SRAM_DQ(dq), .SRAM_CE(ce), .SRAM_OE(oe),
        .SRAM_WE(we), .SRAM_UB(ub), .SRAM_LB(lb)
    );
    assign dq = (!ce && !oe && we) ? mem[sa] : {DW{1'bz}};
    always @(posedge clk) if (!ce && !we) mem[sa] <= dq;

    // RD_WAIT=3 instance
    sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();
    wire  [DW-1:0] dq3;
    logic [AW-1:0] sa3;
    logic ce3, oe3, we3, ub3, lb3;
    logic [DW-1:0] mem3 [0:(1<<AW)-1];

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(3)) u_dut3 (
        .CLK50(clk), .reset(rst), .bus(bus3.slave),
        .SRAM_ADDR(sa3), .SRAM_DQ(dq3), .SRAM_CE(ce3), .SRAM_OE(oe3),
        .SRAM_WE(we3), .SRAM_UB(ub3), .SRAM_LB(lb3)
    );
    assign dq3 = (!ce3 && !oe3 && we3) ? mem3[sa3] : {DW{1'bz}};
    always @(posedge clk) if (!ce3 && !we3) mem3[sa3] <= dq3;

    // Reference model: what a reader should see, and the recording length
    logic [DW-1:0] ref_mem [int];
    logic [AW:0]   ref_len = '0;
    logic [DW-1:0] last_rd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    task automatic run_txn(input bit is_rd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int cyc = 0, we_lo = 0, oe_lo = 0, ce_lo = 0;
        int exp_lat, exp_oe, exp_we, exp_ce;
        bit got = 1'b0, wrong = 1'b0, skip = 1'b0;
        logic [AW-1:0] pin_addr = '0;
        logic [DW-1:0] exp_data;
`ifdef SRAM_CTRL_RECLEN_EN
        if (is_rd && ({1'b0, addr} >= ref_len)) skip = 1'b1;
`endif
        exp_lat  = is_rd ? (skip ? 1 : 2 + RW) : 3;
        exp_oe   = (is_rd && !skip) ? RW + 1 : 0;
        exp_we   = is_rd ? 0 : 1;
        exp_ce   = is_rd ? (skip ? 0 : RW + 1) : 2;
        exp_data = skip ? '0 : ref_read(addr);

        @(negedge clk);
        if (is_rd) begin
            bus.rd_req = 1'b1; bus.rd_addr = addr;
        end else begin
            bus.wr_req = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        end
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (!we) begin we_lo++; pin_addr = sa; end
            if (!oe) begin oe_lo++; pin_addr = sa; end
            if (!ce) ce_lo++;
            if (is_rd ? bus.wr_ack : bus.rd_ack) wrong = 1'b1;
            if (is_rd ? bus.rd_ack : bus.wr_ack) got = 1'b1;
        end
        check_eq(is_rd ? "rd_latency" : "wr_latency", 32'(cyc), 32'(exp_lat));
        check_eq("oe_low_cycles", 32'(oe_lo), 32'(exp_oe));
        check_eq("we_low_cycles", 32'(we_lo), 32'(exp_we));
        check_eq("ce_low_cycles", 32'(ce_lo), 32'(exp_ce));
        check_eq("wrong_ack", 32'(wrong), 32'd0);
        check_eq("busy_in_ack", 32'(bus.busy), 32'd1);
        if (exp_oe + exp_we > 0) check_eq("pin_addr", 32'(pin_addr), 32'(addr));
        if (is_rd) check_eq("rd_data", 32'(bus.rd_data), 32'(exp_data));
        @(negedge clk);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        @(posedge clk); #1;
        check_eq("busy_after", 32'(bus.busy), 32'd0);
        check_eq("ack_one_cycle", 32'(bus.rd_ack | bus.wr_ack), 32'd0);
        if (is_rd) begin
            last_rd = exp_data;
        end else begin
            check_eq("rd_data_held", 32'(bus.rd_data), 32'(last_rd));
            ref_mem[int'(addr)] = data;
            if ({1'b0, addr} + 1 > ref_len) ref_len = {1'b0, addr} + 1;
        end
`ifdef SRAM_CTRL_RECLEN_EN
        check_eq("rec_len", 32'(bus.rec_len), 32'(ref_len));
`endif
        $display("txn %s addr=0x%05h data=0x%04h lat=%0d skip=%0d", is_rd ? "RD" : "WR",
                 addr, is_rd ? exp_data : data, cyc, skip);
    endtask

    task automatic run3(input bit is_rd, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output int lat, output int oe_lo);
        lat = 0; oe_lo = 0;
        @(negedge clk);
        if (is_rd) begin
            bus3.rd_req = 1'b1; bus3.rd_addr = addr;
        end else begin
            bus3.wr_req = 1'b1; bus3.wr_addr = addr; bus3.wr_data = data;
        end
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!oe3) oe_lo++;
            if (bus3.rd_ack || bus3.wr_ack) break;
        end
        @(negedge clk);
        bus3.rd_req = 1'b0;
        bus3.wr_req = 1'b0;
        $display("txn3 %s addr=0x%05h lat=%0d oe_low=%0d", is_rd ? "RD" : "WR", addr, lat, oe_lo);
    endtask

`ifdef SRAM_CTRL_RECLEN_EN
    task automatic pulse_clear();
        @(negedge clk); bus.rec_clear = 1'b1;
        @(negedge clk); bus.rec_clear = 1'b0;
        ref_len = '0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_at, wr_at, cyc, acks, lat, oe_lo;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]  = '0;
            mem3[i] = '0;
        end
        mem3[18'h77] = 16'hA5A5;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_req = 0; bus.rd_addr = '0;
        bus3.wr_req = 0; bus3.wr_addr = '0; bus3.wr_data = '0; bus3.rd_req = 0; bus3.rd_addr = '0;
`ifdef SRAM_CTRL_RECLEN_EN
        bus.rec_clear = 1'b0;
        bus3.rec_clear = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ce", 32'(ce), 32'd1);
        check_eq("rst_oe", 32'(oe), 32'd1);
        check_eq("rst_we", 32'(we), 32'd1);
        check_eq("rst_addr", 32'(sa), 32'd0);
        check_eq("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check_eq("rst_acks", 32'(bus.rd_ack | bus.wr_ack), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("byte_en", 32'({ub, lb}), 32'd0);
`ifdef SRAM_CTRL_RECLEN_EN
        check_eq("rst_rec_len", 32'(bus.rec_len), 32'd0);
`endif
        @(negedge clk); rst = 1'b0;

        // Basic write then read-back
        run_txn(1'b0, 18'h00005, 16'h1234);
        run_txn(1'b1, 18'h00005, 16'h0000);

        // Simultaneous requests: read wins, write follows four cycles after the read ack
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_addr = 18'h10;
        bus.wr_req = 1'b1; bus.wr_addr = 18'h20; bus.wr_data = 16'hBEEF;
        rd_at = 0; wr_at = 0; cyc = 0;
        while (wr_at == 0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.rd_ack) rd_at = cyc;
            if (bus.wr_ack) wr_at = cyc;
            @(negedge clk);
            if (rd_at != 0) bus.rd_req = 1'b0;
            if (wr_at != 0) bus.wr_req = 1'b0;
        end
`ifdef SRAM_CTRL_RECLEN_EN
        check_eq("sim_rd_first", 32'(rd_at), ({1'b0, 18'h10} >= ref_len) ? 32'd1 : 32'(2 + RW));
`else
        check_eq("sim_rd_first", 32'(rd_at), 32'(2 + RW));
`endif
        check_eq("sim_wr_after", 32'(wr_at - rd_at), 32'd4);
        check_eq("sim_mem", 32'(mem[18'h20]), 32'hBEEF);
        ref_mem[32'h20] = 16'hBEEF;
        if (ref_len < 19'h21) ref_len = 19'h21;
        $display("txn SIM rd_ack@%0d wr_ack@%0d", rd_at, wr_at);
        repeat (2) @(posedge clk);

        // Reset during WR_PULSE aborts the access without an ack
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = 18'h00005; bus.wr_data = 16'hDEAD;
        @(posedge clk); #1;
        check_eq("abort_we_low", 32'(we), 32'd0);
        @(negedge clk); rst = 1'b1; #1;
        check_eq("abort_ce", 32'(ce), 32'd1);
        check_eq("abort_we", 32'(we), 32'd1);
        check_eq("abort_oe", 32'(oe), 32'd1);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        bus.wr_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        ref_len = '0;
        last_rd = '0;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.wr_ack || bus.rd_ack) acks++;
        end
        check_eq("abort_no_ack", 32'(acks), 32'd0);
        check_eq("abort_no_write", 32'(mem[18'h5]), 32'h1234);
        $display("txn RST during WR_PULSE");

        // Long read window on the RD_WAIT=3 instance
`ifdef SRAM_CTRL_RECLEN_EN
        run3(1'b0, 18'h80, 16'h0000, lat, oe_lo);
`endif
        run3(1'b1, 18'h77, 16'h0000, lat, oe_lo);
        check_eq("rw3_latency", 32'(lat), 32'd5);
        check_eq("rw3_oe_low", 32'(oe_lo), 32'd4);
        check_eq("rw3_data", 32'(bus3.rd_data), 32'hA5A5);

`ifdef SRAM_CTRL_RECLEN_EN
        pulse_clear();
        for (int a = 0; a < 10; a++) run_txn(1'b0, 18'(a), 16'(16'h100 + a));
        check_eq("len_ten", 32'(bus.rec_len), 32'd10);
        run_txn(1'b1, 18'd12, 16'h0000);
        run_txn(1'b1, 18'd9, 16'h0000);
        run_txn(1'b0, 18'h3FFFF, 16'h7777);
        check_eq("len_top", 32'(bus.rec_len), 32'h40000);
        pulse_clear();
        #1;
        check_eq("len_cleared", 32'(bus.rec_len), 32'd0);
        // Clear held across a write's ACK wins over the length update
        @(negedge clk); bus.rec_clear = 1'b1;
        run_txn(1'b0, 18'd3, 16'h3333);
        bus.rec_clear = 1'b0;
        ref_len = '0;
        @(posedge clk); #1;
        check_eq("clear_wins", 32'(bus.rec_len), 32'd0);
`endif

        // Random mix against the model
        for (int n = 0; n < 150; n++) begin
`ifdef SRAM_CTRL_RECLEN_EN
            if ($urandom_range(0, 39) == 0) pulse_clear();
`endif
            if ($urandom_range(0, 1) == 0)
                run_txn(1'b0, 18'($urandom_range(0, 31)), 16'($urandom));
            else
                run_txn(1'b1, 18'($urandom_range(0, 31)), 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
